// File: rtl/writeback_queue.sv
// Writeback queue: buffers multi-cycle unit writebacks behind the single register-file write port.
// Define WRITEBACK_FORWARD_EN to enable the lookup/forwarding search; otherwise lookup outputs are tied to 0.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        priority_valid,
  input  logic [4:0]  priority_address,
  input  logic [31:0] priority_value,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_address,
  input  logic [31:0] in_value,
  output logic [4:0]  write_address,
  output logic [31:0] write_value,
  input  logic [4:0]  lookup_address,
  output logic        lookup_hit,
  output logic [31:0] lookup_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [4:0]       entry_address [DEPTH];
  logic [31:0]      entry_value   [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign in_ready = !reset && (count < CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but never occupy a slot.
  assign do_push  = in_valid && in_ready && (in_address != 5'd0);
  assign do_pop   = (count != '0) && !priority_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_address[tail] <= in_address;
      entry_value[tail]   <= in_value;
    end
  end

  // Head is hidden while reset is high so a reset mid-drain never commits a pending entry.
  always_comb begin
    write_address = 5'd0;
    write_value   = 32'd0;
    if (priority_valid) begin
      write_address = priority_address;
      write_value   = priority_value;
    end else if (!reset && (count != '0)) begin
      write_address = entry_address[head];
      write_value   = entry_value[head];
    end
  end

`ifdef WRITEBACK_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to newest so the last match, the newest pending write, wins.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_value = 32'd0;
    idx          = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (!reset && (lookup_address != 5'd0) && (CNT_W'(i) < count) &&
          (entry_address[idx] == lookup_address)) begin
        lookup_hit   = 1'b1;
        lookup_value = entry_value[idx];
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^lookup_address;
  assign lookup_hit    = 1'b0;
  assign lookup_value  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vectors with hand-computed expectations plus a
// scoreboard monitor that checks every cycle's write port, in_ready and lookup against a queue model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
`ifdef WRITEBACK_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        priority_valid;
  logic [4:0]  priority_address;
  logic [31:0] priority_value;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_address;
  logic [31:0] in_value;
  logic [4:0]  write_address;
  logic [31:0] write_value;
  logic [4:0]  lookup_address;
  logic        lookup_hit;
  logic [31:0] lookup_value;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] v;
  } entry_t;

  entry_t mq[$];
  bit     started = 1'b0;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .priority_valid(priority_valid),
    .priority_address(priority_address),
    .priority_value(priority_value),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_address(in_address),
    .in_value(in_value),
    .write_address(write_address),
    .write_value(write_value),
    .lookup_address(lookup_address),
    .lookup_hit(lookup_hit),
    .lookup_value(lookup_value)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pval,
                               input logic iv, input logic [4:0] ia, input logic [31:0] ival,
                               input logic [4:0] la, input logic rst);
    priority_valid   = pv;
    priority_address = pa;
    priority_value   = pval;
    in_valid         = iv;
    in_address       = ia;
    in_value         = ival;
    lookup_address   = la;
    reset            = rst;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] la);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la, 1'b0);
  endtask

  // Reference queue model, advanced on the same edge the DUT commits.
  always @(posedge clk) begin
    bit acc;
    bit pop;
    started = 1'b1;
    if (reset) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pop = !priority_valid && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (acc && (in_address != 5'd0)) mq.push_back('{a: in_address, v: in_value});
    end
  end

  // Monitor: compares the presented outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [4:0]  ea;
    logic [31:0] ev;
    logic        eh;
    logic [31:0] elv;
    if (started) begin
      checkOutput("mon_in_ready", 32'(in_ready), 32'(!reset && (mq.size() < DEPTH)));
      ea = 5'd0;
      ev = 32'd0;
      if (priority_valid) begin
        ea = priority_address;
        ev = priority_value;
      end else if (!reset && (mq.size() > 0)) begin
        ea = mq[0].a;
        ev = mq[0].v;
      end
      checkOutput("mon_write_address", 32'(write_address), 32'(ea));
      if (!reset) begin
        checkOutput("mon_write_value", write_value, ev);
        eh  = 1'b0;
        elv = 32'd0;
        if (FWD && (lookup_address != 5'd0)) begin
          for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!eh && (mq[i].a == lookup_address)) begin
              eh  = 1'b1;
              elv = mq[i].v;
            end
          end
        end
        checkOutput("mon_lookup_hit", 32'(lookup_hit), 32'(eh));
        checkOutput("mon_lookup_value", lookup_value, elv);
      end
    end
  end

  // Priority stall scenario table: one row per cycle.
  logic        s_pv   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        s_iv   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [4:0]  s_ia   [12] = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd7, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [31:0] s_ival [12] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hE, 32'hE, 32'hE, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        s_rdy  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [4:0]  s_wa   [12] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd0};
  logic [31:0] s_wv   [12] = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h11, 32'h11,
                               32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'h0};

  initial begin
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    tick();
    tick();

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) begin
      idle(5'd0);
      tick();
    end
    idle(5'd0);
    checkOutput("idle_write_address", 32'(write_address), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_lookup_hit", 32'(lookup_hit), 32'd0);

    $display("[TB] single push latency");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 1'b0);
    checkOutput("push_in_ready", 32'(in_ready), 32'd1);
    tick();
    idle(5'd0);
    checkOutput("push_write_address", 32'(write_address), 32'd5);
    checkOutput("push_write_value", write_value, 32'hDEADBEEF);
    tick();
    idle(5'd0);
    checkOutput("push_after_write_address", 32'(write_address), 32'd0);
    tick();

    $display("[TB] priority stall and full queue");
    for (int c = 0; c < 12; c++) begin
      applyStimulus(s_pv[c], 5'd1, 32'h11, s_iv[c], s_ia[c], s_ival[c], 5'd0, 1'b0);
      checkOutput($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'(s_rdy[c]));
      checkOutput($sformatf("stall_write_address_c%0d", c), 32'(write_address), 32'(s_wa[c]));
      checkOutput($sformatf("stall_write_value_c%0d", c), write_value, s_wv[c]);
      tick();
    end

    $display("[TB] push to r0");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 1'b0);
    checkOutput("r0_in_ready", 32'(in_ready), 32'd1);
    tick();
    idle(5'd0);
    checkOutput("r0_write_address", 32'(write_address), 32'd0);
    checkOutput("r0_in_ready_after", 32'(in_ready), 32'd1);
    tick();

    $display("[TB] lookup of duplicate register");
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h1, 5'd9, 1'b0);
    checkOutput("lk_hit_empty", 32'(lookup_hit), 32'd0);
    checkOutput("lk_prio_address", 32'(write_address), 32'd8);
    tick();
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h2, 5'd9, 1'b0);
    checkOutput("lk_hit_one", 32'(lookup_hit), 32'(FWD));
    checkOutput("lk_value_one", lookup_value, FWD ? 32'h1 : 32'h0);
    tick();
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 5'd9, 1'b0);
    checkOutput("lk_hit_two", 32'(lookup_hit), 32'(FWD));
    checkOutput("lk_value_two", lookup_value, FWD ? 32'h2 : 32'h0);
    tick();
    idle(5'd9);
    checkOutput("lk_drain1_address", 32'(write_address), 32'd9);
    checkOutput("lk_drain1_value", write_value, 32'h1);
    checkOutput("lk_drain1_lookup", lookup_value, FWD ? 32'h2 : 32'h0);
    tick();
    idle(5'd9);
    checkOutput("lk_drain2_address", 32'(write_address), 32'd9);
    checkOutput("lk_drain2_value", write_value, 32'h2);
    checkOutput("lk_drain2_hit", 32'(lookup_hit), 32'(FWD));
    tick();
    idle(5'd9);
    checkOutput("lk_done_address", 32'(write_address), 32'd0);
    checkOutput("lk_done_hit", 32'(lookup_hit), 32'd0);
    tick();

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 5'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h103, 5'd10, 1'b1);
    checkOutput("rst_write_address", 32'(write_address), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    idle(5'd10);
    checkOutput("rst_after_write_address", 32'(write_address), 32'd0);
    checkOutput("rst_after_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_after_lookup_hit", 32'(lookup_hit), 32'd0);
    tick();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("rst_prio_address", 32'(write_address), 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(5'd0);
      checkOutput($sformatf("rst_quiet_c%0d", i), 32'(write_address), 32'd0);
      tick();
    end

    checkOutput("scoreboard_empty", 32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
